slow_dmem: RTL and testbench
============================

SLOW_DMEM -- requirements
Module: slow_dmem

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning wait cycles between request accept and the mem_ready pulse (legal range 1..15).
REQ-002 The block SHALL have parameter AW, default 8, meaning log2 of memory depth in 32-bit words.
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port mem_read  input  1  CPU read request, held until mem_ready.
REQ-006 Port mem_write  input  1  CPU write request, held until mem_ready.
REQ-007 Port mem_addr  input  30  CPU word address.
REQ-008 Port mem_wdata  input  32  CPU write data.
REQ-009 Port mem_rdata  output  32  read data.
REQ-010 Port mem_ready  output  1  one-cycle access-complete pulse.
REQ-011 Port mon_addr  output  30  latched address of the current write, to the downstream result checker.
REQ-012 Port mon_data  output  32  latched data of the current write, to the checker.
REQ-013 Port mon_wen  output  1  write-in-progress flag to the checker.
REQ-014 Port proto_err  output  1  sticky protocol-violation flag.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE; the reset state is IDLE.
REQ-016 In IDLE with mem_read or mem_write high, the block SHALL latch the operation, mem_addr and mem_wdata, load the counter with LATENCY-1, and go to BUSY.
REQ-017 If mem_read and mem_write are both high at accept, the block SHALL perform a write and set proto_err.
REQ-018 In BUSY the counter SHALL decrement each cycle; at zero, mem_ready SHALL be 1 for that cycle and the FSM SHALL go to DONE.
REQ-019 Request-latency rule: for LATENCY=N, mem_ready SHALL assert exactly N cycles after the accept edge.
REQ-020 Writes SHALL commit to the array on the mem_ready cycle edge, using only the latched values.
REQ-021 Input changes after accept SHALL be ignored.
REQ-022 On a read, mem_rdata SHALL be valid in the mem_ready cycle and held until the next read completes.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE with no new accept in that cycle, even if a request is still high.
REQ-024 If a request is dropped before mem_ready, the access SHALL still complete and proto_err SHALL be set.
REQ-025 Addressing SHALL use mem_addr[AW-1:0]; upper bits are ignored, so addresses wrap modulo 2^AW.
REQ-026 mon_wen SHALL be 1 from the cycle after a write accept through the mem_ready cycle inclusive, and 0 otherwise.
REQ-027 While mon_wen is 1, mon_addr and mon_data SHALL equal the latched values; while mon_wen is 0 they SHALL hold their last value.
REQ-028 Each write SHALL produce exactly one contiguous mon_wen high run, so the checker counts it once despite the stall.
REQ-029 Reads SHALL never assert mon_wen.

Reset
REQ-030 On rst low, the block SHALL immediately set: FSM IDLE, counter 0, mem_ready 0, mem_rdata 0, mon_addr 0, mon_data 0, mon_wen 0, proto_err 0, and all array words 0.
REQ-031 Reset asserted mid-access SHALL abort the access with no array write and no mem_ready.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=0, BUSY=1, DONE=2, 2 bits), the TEST_PORT constant 30'hFF, and the BEGIN 32'h168 and END 32'hD5D symbol constants.
REQ-033 The storage array SHALL be a sub-module dmem_array with one synchronous write port and one combinational read port; FSM and monitor logic remain in slow_dmem.

Verification
REQ-034 Write 32'hDEADBEEF to addr 5 with LATENCY=4 -> mem_ready exactly 4 cycles after accept; mon_wen high 4 cycles with mon_addr=5; a later read of addr 5 returns 32'hDEADBEEF.
REQ-035 Write addr 30'h105 with AW=8, then read addr 5 -> read returns the written data (wrap-around).
REQ-036 Write 32'h168 to addr 30'hFF with mem_write held one cycle past mem_ready -> single mon_wen run; DONE blocks re-accept; proto_err stays 0.
REQ-037 mem_read and mem_write both high with data 7 to addr 3 -> write performed; proto_err=1 until reset.
REQ-038 rst pulsed low during the BUSY phase of a write to addr 9 -> no mem_ready; a later read of addr 9 returns 0.
REQ-039 Back-to-back writes to addr 30'hFF of values 0,1,1,1,1,0,32'hD5D at LATENCY=1 -> seven separate mon_wen runs with matching mon_data.

Source files
------------

// File: rtl/slow_dmem_pkg.sv
// Shared constants and types for the slow data memory model.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package slow_dmem_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  // FSM encoding, kept as plain 2-bit constants for legacy tools
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Well-known word address and the begin/end markers the result checker watches for
  localparam logic [ADDR_W-1:0] TEST_PORT = 30'hFF;
  localparam logic [DATA_W-1:0] SYM_BEGIN = 32'h168;
  localparam logic [DATA_W-1:0] SYM_END   = 32'hD5D;

  // Latched write seen by the downstream checker
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mon_t;

  // Counter preload so that mem_ready lands LATENCY edges after accept
  function automatic logic [3:0] lat_to_cnt(input int lat);
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/slow_dmem_if.sv
// CPU-side request/response bundle plus the write-monitor tap.
// Latency: n/a (wiring only).
// Backpressure: request is held by the CPU until the mem_ready pulse.
interface slow_dmem_if;
  import slow_dmem_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] mon_addr;
  logic [DATA_W-1:0] mon_data;
  logic              mon_wen;
  logic              proto_err;

  // CPU / stimulus side
  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mon_addr, mon_data, mon_wen, proto_err
  );

  // Memory side
  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mon_addr, mon_data, mon_wen, proto_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word-addressed storage: one synchronous write port, one combinational read port.
// Latency: write lands on the clock edge, read is same-cycle.
// Backpressure: none; caller owns sequencing.
module dmem_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Storage update; every word clears on reset so an aborted write leaves zeros
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/slow_dmem.sv
// Slow single-port data memory: fixed-latency CPU access with a write monitor tap.
// Latency: mem_ready pulses LATENCY cycles after accept, then one DONE cycle.
// Backpressure: one access in flight; requests are ignored outside IDLE.
module slow_dmem
  import slow_dmem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int AW      = 8
) (
  input logic         clk,
  input logic         rst,
  slow_dmem_if.slave  bus
);

  logic [1:0]        state_q;
  logic [3:0]        cnt_q;
  logic              op_wr_q;
  logic [AW-1:0]     addr_q;
  logic              ready_q;
  logic [DATA_W-1:0] rdata_q;
  mon_t              mon_q;
  logic              mon_wen_q;
  logic              err_q;

  logic              accept;
  logic              ready_nxt;
  logic              rd_nxt;
  logic              req_drop;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] arr_rdata;
  logic              arr_we;

  assign accept    = (state_q == ST_IDLE) && (bus.mem_read || bus.mem_write);

  // mem_ready is registered, so it is computed one edge ahead of the ready cycle
  assign ready_nxt = accept ? (LATENCY == 1)
                            : ((state_q == ST_BUSY) && (cnt_q == 4'd1));

  // A write wins when both strobes are up, so only a pure read loads rdata
  assign rd_nxt    = accept ? !bus.mem_write : !op_wr_q;
  assign rd_addr   = accept ? bus.mem_addr[AW-1:0] : addr_q;

  // The strobe of the latched operation must stay up through the ready cycle
  assign req_drop  = (state_q == ST_BUSY) &&
                     (op_wr_q ? !bus.mem_write : !bus.mem_read);

  // ready_q is only ever high in the final BUSY cycle, which is the commit point
  assign arr_we    = ready_q && op_wr_q;

  dmem_array #(.AW(AW)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .waddr (mon_q.addr[AW-1:0]),
    .wdata (mon_q.data),
    .raddr (rd_addr),
    .rdata (arr_rdata)
  );

  // Access sequencing: accept in IDLE, count down in BUSY, one DONE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_BUSY;
            cnt_q   <= lat_to_cnt(LATENCY);
            op_wr_q <= bus.mem_write;
            addr_q  <= bus.mem_addr[AW-1:0];
          end
        end
        ST_BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // One-cycle completion pulse aligned with the last BUSY cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_nxt;
    end
  end

  // Read data appears with the ready pulse and holds until the next read completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (ready_nxt && rd_nxt) begin
      rdata_q <= arr_rdata;
    end
  end

  // Monitor tap: latch the write at accept, flag it until the ready cycle ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mon_q     <= '0;
      mon_wen_q <= 1'b0;
    end else if (accept && bus.mem_write) begin
      mon_q     <= '{addr: bus.mem_addr, data: bus.mem_wdata};
      mon_wen_q <= 1'b1;
    end else if (ready_q) begin
      mon_wen_q <= 1'b0;
    end
  end

  // Sticky protocol error: conflicting strobes at accept or a request dropped early
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((accept && bus.mem_read && bus.mem_write) || req_drop) begin
      err_q <= 1'b1;
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.mon_addr  = mon_q.addr;
  assign bus.mon_data  = mon_q.data;
  assign bus.mon_wen   = mon_wen_q;
  assign bus.proto_err = err_q;

endmodule

// File: tb/tb_slow_dmem.sv
// Scoreboard bench for slow_dmem: two instances (LATENCY 4 and 1) driven in turn.
// Expectations come from a flat array model and are queued when a request is issued;
// a negedge monitor pops them whenever mem_ready or a mon_wen run shows up.
module tb_slow_dmem;
  import slow_dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  slow_dmem_if b4 ();
  slow_dmem_if b1 ();

  slow_dmem #(.LATENCY(4), .AW(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  slow_dmem #(.LATENCY(1), .AW(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct { int d; logic rd; logic [31:0] data; } op_t;
  typedef struct { int d; logic [29:0] addr; logic [31:0] data; } wr_t;

  op_t         exp_op[$];
  wr_t         exp_wr[$];
  logic [31:0] ref_mem [2][256];
  logic        exp_err [2];

  int          total = 0;
  int          bad   = 0;

  bit          in_run     [2];
  int          run_len    [2];
  logic [29:0] run_addr   [2];
  logic [31:0] run_data   [2];
  bit          run_stable [2];
  logic [29:0] held_addr  [2];
  logic [31:0] held_data  [2];
  logic [31:0] last_rd    [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d actual=%h required=%h t=%0t", name, d, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int d);
    total++;
    bad++;
    $display("FAIL %s dut=%0d actual=present required=absent t=%0t", name, d, $time);
  endtask

  task automatic drive(input int d, input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] w);
    if (d == 0) begin
      b4.mem_read = rd; b4.mem_write = wr; b4.mem_addr = a; b4.mem_wdata = w;
    end else begin
      b1.mem_read = rd; b1.mem_write = wr; b1.mem_addr = a; b1.mem_wdata = w;
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? b4.mem_ready : b1.mem_ready;
  endfunction

  function automatic logic get_err(input int d);
    return (d == 0) ? b4.proto_err : b1.proto_err;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      exp_err[d] = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[d][i] = '0;
    end
  endtask

  // Monitor step for one instance, called at every falling edge
  task automatic mon_step(input int d, input logic rdy, input logic [31:0] rdata,
                          input logic wen, input logic [29:0] ma, input logic [31:0] md);
    op_t o;
    wr_t w;
    if (!rst) begin
      in_run[d] = 0; run_len[d] = 0;
      last_rd[d] = '0; held_addr[d] = '0; held_data[d] = '0;
      return;
    end
    if (rdy) begin
      if (exp_op.size() == 0 || exp_op[0].d != d) begin
        fail_now("unexpected_ready", d);
      end else begin
        o = exp_op.pop_front();
        if (o.rd) begin
          chk("read_data", d, rdata, o.data);
          last_rd[d] = o.data;
        end else begin
          chk("rdata_hold", d, rdata, last_rd[d]);
        end
      end
    end
    if (wen) begin
      if (!in_run[d]) begin
        in_run[d] = 1; run_len[d] = 1;
        run_addr[d] = ma; run_data[d] = md; run_stable[d] = 1;
      end else begin
        run_len[d]++;
        if (ma !== run_addr[d] || md !== run_data[d]) run_stable[d] = 0;
      end
    end else begin
      if (in_run[d]) begin
        in_run[d] = 0;
        if (exp_wr.size() == 0 || exp_wr[0].d != d) begin
          fail_now("unexpected_wen_run", d);
        end else begin
          w = exp_wr.pop_front();
          chk("wen_run_len", d, 32'(run_len[d]), 32'(lat_of(d)));
          chk("mon_addr", d, 32'(run_addr[d]), 32'(w.addr));
          chk("mon_data", d, run_data[d], w.data);
          chk("mon_stable", d, 32'(run_stable[d]), 32'd1);
        end
        held_addr[d] = run_addr[d];
        held_data[d] = run_data[d];
      end
      chk("mon_addr_hold", d, 32'(ma), 32'(held_addr[d]));
      chk("mon_data_hold", d, md, held_data[d]);
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, b4.mem_ready, b4.mem_rdata, b4.mon_wen, b4.mon_addr, b4.mon_data);
    mon_step(1, b1.mem_ready, b1.mem_rdata, b1.mon_wen, b1.mon_addr, b1.mon_data);
  end

  // One access; entered and left #1 after a rising edge with the FSM idle
  task automatic access(input int d, input logic rd, input logic wr,
                        input logic [29:0] a, input logic [31:0] w,
                        input bit drop, input bit hold);
    int n;
    bit seen;
    logic [7:0] ia;
    ia = a[7:0];
    if (wr) begin
      ref_mem[d][ia] = w;
      exp_wr.push_back('{d: d, addr: a, data: w});
      exp_op.push_back('{d: d, rd: 1'b0, data: '0});
      if (rd) exp_err[d] = 1'b1;
    end else begin
      exp_op.push_back('{d: d, rd: 1'b1, data: ref_mem[d][ia]});
    end
    if (drop) exp_err[d] = 1'b1;
    drive(d, rd, wr, a, w);
    @(posedge clk); #1;
    // Scramble address/data after accept; only the latched values may matter
    drive(d, rd, wr, 30'($urandom), $urandom);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (get_ready(d)) seen = 1;
      else if (drop) drive(d, 1'b0, 1'b0, 30'($urandom), $urandom);
    end
    chk("ready_latency", d, 32'(n), 32'(lat_of(d)));
    @(posedge clk); #1;
    if (hold) begin
      @(posedge clk); #1;
    end
    drive(d, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    chk("proto_err", d, 32'(get_err(d)), 32'(exp_err[d]));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    exp_op.delete();
    exp_wr.delete();
    clear_model();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input int d);
    if (d == 0) begin
      chk("rst_ready", d, 32'(b4.mem_ready), 32'd0);
      chk("rst_rdata", d, b4.mem_rdata, 32'd0);
      chk("rst_mon_wen", d, 32'(b4.mon_wen), 32'd0);
      chk("rst_mon_addr", d, 32'(b4.mon_addr), 32'd0);
      chk("rst_mon_data", d, b4.mon_data, 32'd0);
      chk("rst_proto_err", d, 32'(b4.proto_err), 32'd0);
    end else begin
      chk("rst_ready", d, 32'(b1.mem_ready), 32'd0);
      chk("rst_rdata", d, b1.mem_rdata, 32'd0);
      chk("rst_mon_wen", d, 32'(b1.mon_wen), 32'd0);
      chk("rst_mon_addr", d, 32'(b1.mon_addr), 32'd0);
      chk("rst_mon_data", d, b1.mon_data, 32'd0);
      chk("rst_proto_err", d, 32'(b1.proto_err), 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog dut=0 actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] seq [7];
    logic [29:0] ra;
    bit          rd;

    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic write then read-back
    access(0, 1'b0, 1'b1, 30'd5, 32'hDEADBEEF, 0, 0);
    access(0, 1'b1, 1'b0, 30'd5, 32'h0, 0, 0);

    // Upper address bits ignored
    access(0, 1'b0, 1'b1, 30'h105, 32'h1234_5678, 0, 0);
    access(0, 1'b1, 1'b0, 30'd5, 32'h0, 0, 0);

    // Request held one cycle past ready: still one run, no re-accept, no error
    access(0, 1'b0, 1'b1, TEST_PORT, SYM_BEGIN, 0, 1);
    access(0, 1'b1, 1'b0, TEST_PORT, 32'h0, 0, 0);

    // Conflicting strobes: write wins and the error is sticky
    access(0, 1'b1, 1'b1, 30'd3, 32'd7, 0, 0);
    access(0, 1'b1, 1'b0, 30'd3, 32'h0, 0, 0);

    // Request dropped mid-access: access still completes
    access(0, 1'b0, 1'b1, 30'd20, 32'hA5A5_0F0F, 1, 0);
    access(0, 1'b1, 1'b0, 30'd20, 32'h0, 0, 0);

    do_reset();
    chk("err_cleared", 0, 32'(b4.proto_err), 32'd0);

    // Reset during BUSY of a write to addr 9 aborts it
    drive(0, 1'b0, 1'b1, 30'd9, 32'hCAFE_F00D);
    @(posedge clk); #1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    chk_reset_vals(0);
    @(posedge clk); #1;
    clear_model();
    exp_op.delete();
    exp_wr.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 30'd9, 32'h0, 0, 0);

    // Back-to-back writes at latency 1 give separate monitor runs
    seq = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0, SYM_END};
    for (int i = 0; i < 7; i++) access(1, 1'b0, 1'b1, TEST_PORT, seq[i], 0, 0);
    access(1, 1'b1, 1'b0, TEST_PORT, 32'h0, 0, 0);

    // Random mix on both instances, small address window with noisy upper bits
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 30; k++) begin
        ra = {22'($urandom), 4'b0000, 4'($urandom)};
        rd = 1'($urandom);
        access(d, rd, !rd, ra, $urandom, 0, 0);
      end
    end

    repeat (10) @(posedge clk);
    #1;
    chk("ops_outstanding", 0, 32'(exp_op.size()), 32'd0);
    chk("wr_runs_outstanding", 0, 32'(exp_wr.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
